// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// FSM state encodings, the "no write" mask and lane/alignment helpers.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE    = 2'd0,
    DMEM_ST_WAIT    = 2'd1,
    DMEM_ST_RESPOND = 2'd2
  } dmem_state_e;

  localparam logic [3:0] DMEM_WMASK_NONE = 4'b0000;

  // Byte lanes touched by a store; lanes pushed past byte 3 fall off.
  function automatic logic [3:0] dmem_lane_mask(
    input logic [3:0] wmask,
    input logic [1:0] off
  );
    logic [3:0] r;
    r = wmask << off;
    return r;
  endfunction

  // Loads count as word accesses; stores take their size from the mask.
  function automatic logic dmem_misaligned(
    input logic [3:0] wmask,
    input logic [1:0] off
  );
    logic is_word;
    is_word = (wmask == DMEM_WMASK_NONE) || (|wmask[3:2]);
    if (is_word) return off != 2'b00;
    if (wmask[1]) return off[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/data_memory_responder_dmem_ram.sv
// Single-port 32-bit RAM with per-byte write enables.
// Read data is registered and only refreshed when en is high.
module dmem_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Read returns the word as it was before any same-edge write.
  always_ff @(posedge clk) begin
    if (en) r_rdata <= r_mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: one request at a time, fixed latency.
// Optional macro DMEM_MISALIGN_ERR_EN adds data_mem_err.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DMEM_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_mem_req,
  input  logic [DMEM_WIDTH-1:0] data_mem_addr,
  input  logic [3:0]            data_mem_wmask,
  input  logic [31:0]           data_mem_write,
  output logic [31:0]           data_mem_read,
  output logic                  data_mem_valid,
  output logic                  data_mem_busy
`ifdef DMEM_MISALIGN_ERR_EN
  ,
  output logic                  data_mem_err
`endif
);

  localparam logic [3:0] LP_LAST = 4'(READ_LATENCY - 2);

  dmem_state_e r_state;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic [1:0]  r_off;
  logic [3:0]  r_mask;
  logic [31:0] r_read;

  logic        w_accept;
  logic        w_to_respond;
  logic [1:0]  w_off;
  logic [3:0]  w_lane;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic [31:0] w_load_data;

  assign w_accept    = (r_state == DMEM_ST_IDLE) && data_mem_req;
  assign w_off       = data_mem_addr[1:0];
  assign w_lane      = dmem_lane_mask(data_mem_wmask, w_off);
  assign w_wdata     = data_mem_write << {w_off, 3'b000};
  assign w_load_data = w_rdata >> {r_off, 3'b000};

`ifdef DMEM_MISALIGN_ERR_EN
  logic w_mis;
  logic r_mis;
  logic r_err;

  assign w_mis = dmem_misaligned(data_mem_wmask, w_off);
  assign w_we  = (w_accept && !w_mis) ? w_lane : 4'b0000;

  // Latch misalignment at acceptance and flag it alongside valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_mis <= w_mis;
      r_err <= w_to_respond &&
               ((r_state == DMEM_ST_IDLE) ? w_mis : r_mis);
    end
  end

  assign data_mem_err = r_err;
`else
  assign w_we = w_accept ? w_lane : 4'b0000;
`endif

  dmem_ram #(
    .AW(DMEM_WIDTH - 2)
  ) u_ram (
    .clk  (clk),
    .en   (w_accept),
    .we   (w_we),
    .addr (data_mem_addr[DMEM_WIDTH-1:2]),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );

  // Decide whether the next edge enters RESPOND.
  always_comb begin
    w_to_respond = 1'b0;
    unique case (r_state)
      DMEM_ST_IDLE: w_to_respond = w_accept && (READ_LATENCY == 1);
      DMEM_ST_WAIT: w_to_respond = (r_cnt == LP_LAST);
      default:      w_to_respond = 1'b0;
    endcase
  end

  // Request FSM with latency counter and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DMEM_ST_IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_off   <= 2'b00;
      r_mask  <= DMEM_WMASK_NONE;
      r_read  <= 32'd0;
    end else begin
      r_valid <= w_to_respond;
      unique case (r_state)
        DMEM_ST_IDLE: begin
          if (data_mem_req) begin
            r_off  <= w_off;
            r_mask <= data_mem_wmask;
            r_cnt  <= 4'd0;
            r_state <= w_to_respond ? DMEM_ST_RESPOND : DMEM_ST_WAIT;
          end
        end
        DMEM_ST_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_to_respond) r_state <= DMEM_ST_RESPOND;
        end
        DMEM_ST_RESPOND: begin
          if (r_mask == DMEM_WMASK_NONE) r_read <= w_load_data;
          r_state <= DMEM_ST_IDLE;
        end
        default: r_state <= DMEM_ST_IDLE;
      endcase
    end
  end

  // Loads drive fresh data in RESPOND; otherwise the last load is held.
  assign data_mem_read =
    ((r_state == DMEM_ST_RESPOND) && (r_mask == DMEM_WMASK_NONE))
      ? w_load_data : r_read;

  assign data_mem_valid = r_valid;
  assign data_mem_busy  = (r_state != DMEM_ST_IDLE);

endmodule
